io_putc_uart: RTL and testbench

- Downstream of the decoder's I/O instruction fields; instantiated inside the I/O path next to the control unit.
- Accepts PUTC requests, with the character coming from the immediate or the register-file read data, and buffers them in a small FIFO.
- Serialises buffered characters onto a UART TX line (8N1).
- Back-pressures the control unit with a combinational stall while the FIFO is full.

---
 rtl/io_putc_uart.sv | 147 ++++++++++++++
 tb/tb_io_putc_uart.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/io_putc_uart.sv
// rtl/io_putc_uart.sv - PUTC request FIFO feeding an 8N1 UART transmitter
package pkg_ram;
  localparam int RAM_BYTE_SIZE = 8;
endpackage

package pkg_io;
  typedef enum logic [1:0] {
    IO_NOP      = 2'd0,
    IO_PUTC_IMM = 2'd1,
    IO_PUTC_REG = 2'd2
  } op_t;
endpackage

module io_putc_uart #(
  parameter int CLK_FREQ   = 12_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              io_valid,
  input  pkg_io::op_t                       io_op,
  input  logic [pkg_ram::RAM_BYTE_SIZE-1:0] io_char_imm,
  input  logic [pkg_ram::RAM_BYTE_SIZE-1:0] io_reg_data,
  output logic                              io_stall,
  output logic                              tx_busy,
  output logic                              uart_tx
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          req;
  logic          full;
  logic          push;
  logic          pop;
  logic [7:0]    char_sel;

  assign req      = io_valid && (io_op == pkg_io::IO_PUTC_IMM || io_op == pkg_io::IO_PUTC_REG);
  assign full     = (count == COUNT_FULL);
  assign io_stall = req && full;
  // Full is the registered count, so a same-cycle pop never admits a push.
  assign push     = req && !full;
  assign pop      = (state == IDLE) && (count != '0);
  assign char_sel = (io_op == pkg_io::IO_PUTC_REG) ? io_reg_data : io_char_imm;
  assign tx_busy  = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= char_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // uart_tx is loaded with the level of the state being entered, keeping the line glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          uart_tx <= 1'b1;
          if (pop) begin
            shift    <= mem[rd_ptr];
            baud_cnt <= '0;
            state    <= START;
            uart_tx  <= 1'b0;
          end
        end
        START: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_tx  <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              uart_tx <= 1'b1;
            end else begin
              shift   <= {1'b0, shift[7:1]};
              bit_idx <= bit_idx + 1'b1;
              uart_tx <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          uart_tx <= 1'b1;
          if (baud_cnt == BAUD_LAST) begin
            baud_cnt <= '0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          uart_tx <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_io_putc_uart.sv
// tb/tb_io_putc_uart.sv - scoreboard bench: timing model for stall/busy, UART receiver for the line
module tb_io_putc_uart;
  import pkg_io::*;

  localparam int CLK_FREQ = 8;
  localparam int BAUD     = 1;
  localparam int DEPTH    = 4;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       io_valid = 1'b0;
  op_t        io_op = IO_NOP;
  logic [7:0] io_char_imm = 8'h00;
  logic [7:0] io_reg_data = 8'h00;
  logic       io_stall;
  logic       tx_busy;
  logic       uart_tx;

  int errors = 0;
  int checks = 0;

  int         m_cnt = 0;
  int         m_next_pop = 0;
  int         m_last_pop = -100000;
  int         edge_n = 0;
  bit         chk_en = 1'b0;
  logic [7:0] exp_q[$];

  bit         mon_en = 1'b0;
  bit         mon_act = 1'b0;
  int         mon_t = 0;
  int         mon_cyc = 0;
  logic       prev_tx = 1'b1;
  logic [7:0] mon_ch = 8'h00;
  int         starts[$];

  always #5 clk = ~clk;

  io_putc_uart #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .io_valid   (io_valid),
    .io_op      (io_op),
    .io_char_imm(io_char_imm),
    .io_reg_data(io_reg_data),
    .io_stall   (io_stall),
    .tx_busy    (tx_busy),
    .uart_tx    (uart_tx)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // One clock of stimulus; the model tracks occupancy and the serialiser's pop times.
  task automatic step(input bit r, input bit v, input op_t op, input logic [7:0] imm,
                      input logic [7:0] rd, output bit acc, output bit stl);
    bit         req;
    bit         pop;
    logic [7:0] ch;
    @(negedge clk);
    rst = r;
    io_valid = v;
    io_op = op;
    io_char_imm = imm;
    io_reg_data = rd;
    req = v && (op == IO_PUTC_IMM || op == IO_PUTC_REG);
    ch = (op == IO_PUTC_REG) ? rd : imm;
    #1;
    stl = io_stall;
    if (chk_en) begin
      check("io_stall", io_stall, (req && m_cnt == DEPTH) ? 1 : 0);
      check("tx_busy", tx_busy, (m_cnt != 0 || (edge_n - m_last_pop) < 10 * CPB) ? 1 : 0);
    end
    @(posedge clk);
    edge_n++;
    acc = 1'b0;
    if (r) begin
      m_cnt = 0;
      m_next_pop = 0;
      m_last_pop = -100000;
      exp_q.delete();
      chk_en = 1'b1;
    end else begin
      pop = (m_cnt > 0) && (edge_n >= m_next_pop);
      acc = req && (m_cnt < DEPTH);
      if (pop) begin
        m_cnt--;
        m_next_pop = edge_n + FRAME;
        m_last_pop = edge_n;
      end
      if (acc) begin
        m_cnt++;
        exp_q.push_back(ch);
      end
    end
  endtask

  task automatic idle(input int n, output bit line_high);
    bit acc;
    bit stl;
    line_high = 1'b1;
    repeat (n) begin
      step(1'b0, 1'b0, IO_NOP, 8'h00, 8'h00, acc, stl);
      if (uart_tx !== 1'b1) line_high = 1'b0;
    end
  endtask

  task automatic put(input op_t op, input logic [7:0] imm, input logic [7:0] rd, output int stalls);
    bit acc;
    bit stl;
    int n;
    n = 0;
    stalls = 0;
    acc = 1'b0;
    while (!acc && n < 300) begin
      step(1'b0, 1'b1, op, imm, rd, acc, stl);
      if (stl) stalls++;
      n++;
    end
    if (!acc) check("put_timeout", 0, 1);
  endtask

  // UART receiver: samples each bit mid-period and pops the scoreboard on the stop bit.
  always @(negedge clk) begin
    #2;
    mon_cyc++;
    if (!mon_en || rst) begin
      mon_act = 1'b0;
      prev_tx = 1'b1;
    end else begin
      if (!mon_act) begin
        if (prev_tx === 1'b1 && uart_tx === 1'b0) begin
          mon_act = 1'b1;
          mon_t = 0;
          starts.push_back(mon_cyc);
        end
      end else begin
        mon_t++;
        if (mon_t == CPB / 2) begin
          check("start_bit", uart_tx, 0);
        end else if (mon_t > CPB / 2 && (mon_t - CPB / 2) % CPB == 0) begin
          if (mon_t < CPB / 2 + 9 * CPB) begin
            mon_ch[(mon_t - CPB / 2) / CPB - 1] = uart_tx;
          end else begin
            check("stop_bit", uart_tx, 1);
            if (exp_q.size() == 0) check("unexpected_frame", 1, 0);
            else check("frame_char", mon_ch, exp_q.pop_front());
            mon_act = 1'b0;
          end
        end
      end
      prev_tx = uart_tx;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit stl;
    bit hi;
    int stalls;

    repeat (3) step(1'b1, 1'b0, IO_NOP, 8'h00, 8'h00, acc, stl);
    #1;
    check("reset_uart_tx", uart_tx, 1);
    check("reset_io_stall", io_stall, 0);
    check("reset_tx_busy", tx_busy, 0);
    mon_en = 1'b1;
    idle(100, hi);
    check("idle_line_high", hi, 1);

    step(1'b0, 1'b1, IO_PUTC_IMM, 8'h41, 8'h00, acc, stl);
    #1;
    check("tx_before_pop", uart_tx, 1);
    step(1'b0, 1'b0, IO_NOP, 8'h00, 8'h00, acc, stl);
    #1;
    check("start_bit_latency", uart_tx, 0);
    idle(FRAME + 10, hi);

    step(1'b0, 1'b1, IO_PUTC_REG, 8'hFF, 8'h5A, acc, stl);
    idle(FRAME + 10, hi);

    starts.delete();
    for (int i = 0; i < 6; i++) begin
      put(IO_PUTC_IMM, 8'h30 + 8'(i), 8'h00, stalls);
      check("burst_stall_cycles", stalls, (i == 5) ? FRAME - 3 : 0);
    end
    idle(6 * FRAME + 20, hi);
    check("burst_frame_count", starts.size(), 6);
    for (int i = 1; i < starts.size(); i++) begin
      check("burst_frame_spacing", starts[i] - starts[i-1], FRAME);
    end

    hi = 1'b1;
    repeat (5) begin
      step(1'b0, 1'b1, IO_NOP, 8'h41, 8'h42, acc, stl);
      if (uart_tx !== 1'b1) hi = 1'b0;
    end
    repeat (5) begin
      step(1'b0, 1'b0, IO_PUTC_IMM, 8'h41, 8'h42, acc, stl);
      if (uart_tx !== 1'b1) hi = 1'b0;
    end
    repeat (5) begin
      step(1'b0, 1'b0, IO_PUTC_REG, 8'h41, 8'h42, acc, stl);
      if (uart_tx !== 1'b1) hi = 1'b0;
    end
    check("ignored_ops_line", hi, 1);
    idle(30, hi);
    check("ignored_ops_idle", hi, 1);

    repeat (400) begin
      step(1'b0, $urandom_range(0, 3) != 0, op_t'($urandom_range(0, 2)),
           8'($urandom), 8'($urandom), acc, stl);
    end
    idle((DEPTH + 1) * FRAME + 20, hi);
    check("random_drained", exp_q.size(), 0);

    step(1'b0, 1'b1, IO_PUTC_IMM, 8'h55, 8'h00, acc, stl);
    step(1'b0, 1'b1, IO_PUTC_IMM, 8'h11, 8'h00, acc, stl);
    step(1'b0, 1'b1, IO_PUTC_REG, 8'h00, 8'h22, acc, stl);
    idle(34, hi);
    #1;
    check("pre_reset_data_bit3", uart_tx, 0);
    step(1'b1, 1'b0, IO_NOP, 8'h00, 8'h00, acc, stl);
    #1;
    check("reset_abort_tx", uart_tx, 1);
    check("reset_abort_busy", tx_busy, 0);
    idle(3 * FRAME, hi);
    check("post_reset_line_high", hi, 1);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
